// File: rtl/text_pixel_pipe_pkg.sv
// Shared constants and counter helpers for the text-mode pixel pipeline.
package text_pixel_pipe_pkg;

    localparam int unsigned CursorLines = 2;
    localparam int unsigned PipeLatency = 4;

    function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned max);
        return (value >= max) ? 32'd0 : value + 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/text_pixel_pipe_cell_tracker.sv
// Incremental character-cell tracker: follows the scan position without dividers.
module text_pixel_pipe_cell_tracker
    import text_pixel_pipe_pkg::*;
#(
    parameter int unsigned CHAR_W = 9,
    parameter int unsigned CHAR_H = 16,
    parameter int unsigned COLS   = 70,
    parameter int unsigned ROWS   = 30
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         valid_in,
    input  logic [9:0]                   h_addr,
    input  logic [9:0]                   v_addr,
    output logic [$clog2(CHAR_W)-1:0]    off_x,
    output logic [$clog2(COLS+1)-1:0]    col,
    output logic [$clog2(CHAR_H)-1:0]    off_y,
    output logic [$clog2(ROWS+1)-1:0]    row
);

    localparam int unsigned XW = $clog2(CHAR_W);
    localparam int unsigned YW = $clog2(CHAR_H);
    localparam int unsigned CW = $clog2(COLS + 1);
    localparam int unsigned RW = $clog2(ROWS + 1);

    logic [XW-1:0] off_x_q, off_x_d;
    logic [CW-1:0] col_q, col_d;
    logic [YW-1:0] off_y_q, off_y_d;
    logic [RW-1:0] row_q, row_d;
    logic [9:0]    last_v_q, last_v_d;
    logic          started_q, started_d;
    logic          line_start;

    assign line_start = valid_in && (h_addr == '0);

    always_comb begin
        off_x_d   = off_x_q;
        col_d     = col_q;
        off_y_d   = off_y_q;
        row_d     = row_q;
        last_v_d  = last_v_q;
        started_d = started_q;
        if (line_start) begin
            started_d = 1'b1;
            off_x_d   = '0;
            col_d     = '0;
            last_v_d  = v_addr;
            if (v_addr == '0) begin
                off_y_d = '0;
                row_d   = '0;
            end else if (v_addr != last_v_q) begin
                off_y_d = YW'(wrap_inc(32'(off_y_q), CHAR_H - 1));
                if (32'(off_y_q) == CHAR_H - 1) begin
                    row_d = RW'(sat_inc(32'(row_q), ROWS));
                end
            end
        end else if (valid_in && started_q) begin
            // Hold at zero until the first line start after reset.
            off_x_d = XW'(wrap_inc(32'(off_x_q), CHAR_W - 1));
            if (32'(off_x_q) == CHAR_W - 1) begin
                col_d = CW'(sat_inc(32'(col_q), COLS));
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            off_x_q   <= '0;
            col_q     <= '0;
            off_y_q   <= '0;
            row_q     <= '0;
            last_v_q  <= '0;
            started_q <= 1'b0;
        end else begin
            off_x_q   <= off_x_d;
            col_q     <= col_d;
            off_y_q   <= off_y_d;
            row_q     <= row_d;
            last_v_q  <= last_v_d;
            started_q <= started_d;
        end
    end

    assign off_x = off_x_q;
    assign col   = col_q;
    assign off_y = off_y_q;
    assign row   = row_q;

endmodule

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel generator: cell tracking, scrolled video/font lookup and a
// blinking underline cursor, at a fixed 4-cycle latency.
module text_pixel_pipe
    import text_pixel_pipe_pkg::*;
#(
    parameter int unsigned CHAR_W       = 9,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned COLS         = 70,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned COLOR_W      = 24,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           clrn,
    input  logic                           valid_in,
    input  logic [9:0]                     h_addr,
    input  logic [9:0]                     v_addr,
    input  logic [$clog2(ROWS)-1:0]        roll_row,
    input  logic                           cursor_en,
    input  logic [$clog2(COLS)-1:0]        cursor_col,
    input  logic [$clog2(ROWS)-1:0]        cursor_row,
    input  logic [COLOR_W-1:0]             color_text,
    input  logic [COLOR_W-1:0]             color_background,
    output logic [$clog2(COLS*ROWS)-1:0]   vm_addr,
    input  logic [7:0]                     vm_data,
    output logic [8+$clog2(CHAR_H)-1:0]    font_addr,
    input  logic [CHAR_W-1:0]              font_line,
    output logic [COLOR_W-1:0]             pixel,
    output logic                           pixel_valid
);

    localparam int unsigned XW     = $clog2(CHAR_W);
    localparam int unsigned YW     = $clog2(CHAR_H);
    localparam int unsigned CW     = $clog2(COLS + 1);
    localparam int unsigned RW     = $clog2(ROWS + 1);
    localparam int unsigned VmW    = $clog2(COLS * ROWS);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [XW-1:0] off_x_1;
    logic [CW-1:0] col_1;
    logic [YW-1:0] off_y_1;
    logic [RW-1:0] row_1;

    text_pixel_pipe_cell_tracker #(
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H),
        .COLS   (COLS),
        .ROWS   (ROWS)
    ) u_cell_tracker (
        .clk      (clk),
        .clrn     (clrn),
        .valid_in (valid_in),
        .h_addr   (h_addr),
        .v_addr   (v_addr),
        .off_x    (off_x_1),
        .col      (col_1),
        .off_y    (off_y_1),
        .row      (row_1)
    );

    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (valid_in && (h_addr == '0) && (v_addr == '0)) begin
            if (32'(blink_cnt_q) >= BLINK_FRAMES - 1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: address math and side-band decisions from the tracker registers.
    int unsigned      mem_row;
    logic [VmW-1:0]   vm_addr_1;
    logic             in_area_1;
    logic             cursor_hit_1;

    always_comb begin
        mem_row = 32'(row_1) + 32'(roll_row);
        if (mem_row >= ROWS) begin
            mem_row = mem_row - ROWS;
        end
        vm_addr_1    = VmW'(mem_row * COLS + 32'(col_1));
        in_area_1    = (32'(col_1) < COLS) && (32'(row_1) < ROWS);
        cursor_hit_1 = cursor_en && phase_q
                       && (32'(row_1) == 32'(cursor_row))
                       && (32'(col_1) == 32'(cursor_col))
                       && (32'(off_y_1) >= CHAR_H - CursorLines);
    end

    // vld_q[i] marks stage i+1 as carrying a displayed pixel.
    logic [PipeLatency-2:0] vld_q;
    logic [XW-1:0]          off_x_2_q, off_x_3_q;
    logic [YW-1:0]          off_y_2_q;
    logic                   in_area_2_q, in_area_3_q;
    logic                   cursor_2_q, cursor_3_q;
    logic [COLOR_W-1:0]     fg_2_q, bg_2_q, fg_3_q, bg_3_q;
    logic [COLOR_W-1:0]     pixel_d;

    assign vm_addr   = vld_q[0] ? vm_addr_1 : '0;
    assign font_addr = vld_q[1] ? {vm_data, off_y_2_q} : '0;

    always_comb begin
        pixel_d = '0;
        if (vld_q[PipeLatency-2]) begin
            pixel_d = (cursor_3_q || (in_area_3_q && font_line[off_x_3_q])) ? fg_3_q : bg_3_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            vld_q       <= '0;
            off_x_2_q   <= '0;
            off_x_3_q   <= '0;
            off_y_2_q   <= '0;
            in_area_2_q <= 1'b0;
            in_area_3_q <= 1'b0;
            cursor_2_q  <= 1'b0;
            cursor_3_q  <= 1'b0;
            fg_2_q      <= '0;
            bg_2_q      <= '0;
            fg_3_q      <= '0;
            bg_3_q      <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            vld_q       <= {vld_q[PipeLatency-3:0], valid_in};
            off_x_2_q   <= off_x_1;
            off_x_3_q   <= off_x_2_q;
            off_y_2_q   <= off_y_1;
            in_area_2_q <= in_area_1;
            in_area_3_q <= in_area_2_q;
            cursor_2_q  <= cursor_hit_1;
            cursor_3_q  <= cursor_2_q;
            fg_2_q      <= color_text;
            bg_2_q      <= color_background;
            fg_3_q      <= fg_2_q;
            bg_3_q      <= bg_2_q;
            pixel       <= pixel_d;
            pixel_valid <= vld_q[PipeLatency-2];
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Randomized bench for text_pixel_pipe against a counting reference model.
module tb_text_pixel_pipe;

    localparam int CharW = 9;
    localparam int CharH = 16;
    localparam int Cols  = 70;
    localparam int Rows  = 30;
    localparam int Blink = 2;

    logic        clk = 1'b0;
    logic        clrn;
    logic        valid_in;
    logic [9:0]  h_addr, v_addr;
    logic [4:0]  roll_row;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [23:0] color_text, color_background;
    logic [11:0] vm_addr;
    logic [7:0]  vm_data;
    logic [11:0] font_addr;
    logic [8:0]  font_line;
    logic [23:0] pixel;
    logic        pixel_valid;

    text_pixel_pipe #(
        .CHAR_W       (CharW),
        .CHAR_H       (CharH),
        .COLS         (Cols),
        .ROWS         (Rows),
        .COLOR_W      (24),
        .BLINK_FRAMES (Blink)
    ) dut (
        .clk              (clk),
        .clrn             (clrn),
        .valid_in         (valid_in),
        .h_addr           (h_addr),
        .v_addr           (v_addr),
        .roll_row         (roll_row),
        .cursor_en        (cursor_en),
        .cursor_col       (cursor_col),
        .cursor_row       (cursor_row),
        .color_text       (color_text),
        .color_background (color_background),
        .vm_addr          (vm_addr),
        .vm_data          (vm_data),
        .font_addr        (font_addr),
        .font_line        (font_line),
        .pixel            (pixel),
        .pixel_valid      (pixel_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] vmem [4096];
    logic [8:0] fmem [4096];

    always @(posedge clk) begin
        vm_data   <= vmem[vm_addr];
        font_line <= fmem[font_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: position as pixel/line counts since the last line/frame start.
    bit          m_started;
    int          pix_cnt, line_cnt, last_v, frames, cyc;
    bit          p_vld;
    int          p_col, p_row, p_offx, p_offy;
    logic [23:0] exp_pix [16];
    bit          exp_vld [16];

    logic [4:0]  nx_roll;
    bit          nx_cur_en;
    logic [6:0]  nx_ccol;
    logic [4:0]  nx_crow;
    logic [23:0] nx_fg, nx_bg;

    task automatic model_reset();
        m_started = 0; pix_cnt = 0; line_cnt = 0; last_v = 0; frames = 0; cyc = 0;
        p_vld = 0; p_col = 0; p_row = 0; p_offx = 0; p_offy = 0;
        for (int i = 0; i < 16; i++) begin
            exp_pix[i] = '0;
            exp_vld[i] = 0;
        end
    endtask

    task automatic model_input(input bit v, input int h, input int vy);
        if (v) begin
            if (h == 0) begin
                m_started = 1;
                pix_cnt   = 0;
                if (vy == 0) begin
                    line_cnt = 0;
                    frames++;
                end else if (vy != last_v) begin
                    line_cnt++;
                end
                last_v = vy;
            end else if (m_started) begin
                pix_cnt++;
            end
        end
        p_vld  = v;
        p_col  = (pix_cnt / CharW > Cols) ? Cols : pix_cnt / CharW;
        p_offx = pix_cnt % CharW;
        p_row  = (line_cnt / CharH > Rows) ? Rows : line_cnt / CharH;
        p_offy = line_cnt % CharH;
    endtask

    // Resolve the previous cycle's pixel using the side-band values now applied.
    task automatic finalize();
        int          mrow, addr, slot;
        logic [8:0]  fl;
        bit          phase, cur, fgsel;
        slot = (cyc + 15) % 16;
        mrow = p_row + int'(roll_row);
        if (mrow >= Rows) mrow -= Rows;
        addr  = mrow * Cols + p_col;
        fl    = fmem[int'(vmem[addr]) * CharH + p_offy];
        phase = ((frames / Blink) % 2) == 1;
        cur   = cursor_en && phase && (p_row == int'(cursor_row))
                && (p_col == int'(cursor_col)) && (p_offy >= CharH - 2);
        fgsel = cur || ((p_col < Cols) && (p_row < Rows) && fl[p_offx]);
        check("vm_addr", 32'(vm_addr), p_vld ? 32'(addr) : 32'd0);
        exp_vld[slot] = p_vld;
        exp_pix[slot] = !p_vld ? 24'd0 : (fgsel ? color_text : color_background);
    endtask

    task automatic step(input bit v, input int h, input int vy);
        int slot;
        @(posedge clk);
        #1;
        slot = (cyc + 12) % 16;
        check("pixel_valid", 32'(pixel_valid), 32'(exp_vld[slot]));
        check("pixel", 32'(pixel), 32'(exp_pix[slot]));
        valid_in         = v;
        h_addr           = 10'(h);
        v_addr           = 10'(vy);
        roll_row         = nx_roll;
        cursor_en        = nx_cur_en;
        cursor_col       = nx_ccol;
        cursor_row       = nx_crow;
        color_text       = nx_fg;
        color_background = nx_bg;
        #1;
        finalize();
        model_input(v, h, vy);
        cyc++;
    endtask

    task automatic run_line(input int vy, input int len, input bit gaps);
        int h;
        h = 0;
        while (h < len) begin
            if (gaps && ($urandom_range(0, 7) == 0)) begin
                step(0, h, vy);
            end else begin
                step(1, h, vy);
                h++;
            end
        end
        repeat (3) step(0, 0, vy);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_vm_addr", 32'(vm_addr), 32'd0);
        valid_in = 1'b0;
        #2;
        clrn = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            vmem[i] = 8'($urandom);
            fmem[i] = 9'($urandom);
        end
        vmem[0]      = 8'h41;
        fmem[12'h410] = 9'h001;
        vm_data = '0; font_line = '0;
        clrn = 1'b0; valid_in = 1'b0; h_addr = '0; v_addr = '0;
        nx_roll = '0; nx_cur_en = 0; nx_ccol = 7'd3; nx_crow = 5'd2;
        nx_fg = 24'hF0F0F0; nx_bg = 24'h102030;
        roll_row = nx_roll; cursor_en = nx_cur_en; cursor_col = nx_ccol; cursor_row = nx_crow;
        color_text = nx_fg; color_background = nx_bg;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        check("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        check("reset_pixel", 32'(pixel), 32'd0);
        check("reset_vm_addr", 32'(vm_addr), 32'd0);
        check("reset_font_addr", 32'(font_addr), 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        // Defaults: 'A' at cell (0,0), full-width lines reach past the text area.
        for (int y = 0; y < 4; y++) run_line(y, 640, 0);

        // Reset while pixels stream out, then a partial line before any line start.
        for (int x = 0; x < 100; x++) step(1, x, 4);
        pulse_reset();
        for (int x = 0; x < 5; x++) step(1, 200 + x, 7);
        repeat (3) step(0, 0, 7);

        // Cursor at (3,2) with scrolling and colour changes.
        nx_cur_en = 1;
        for (int f = 0; f < 6; f++) begin
            nx_roll = (f == 0) ? 5'd29 : (f == 1) ? 5'd5 : 5'($urandom_range(0, Rows - 1));
            for (int y = 0; y < 50; y++) begin
                nx_fg = 24'($urandom);
                nx_bg = 24'($urandom);
                if (f == 5) nx_roll = 5'($urandom_range(0, Rows - 1));
                run_line(y, (y % 10 == 0) ? 640 : 40, 1);
            end
        end

        // Tall frame: row saturation below the text area and repeated line numbers.
        nx_roll = 5'($urandom_range(0, Rows - 1));
        for (int y = 0; y < 500; y++) begin
            run_line(y, (y % 100 == 50) ? 640 : 12, 0);
            if (y % 50 == 25) run_line(y, 12, 0);
        end
        repeat (6) step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/text_pixel_pipe.md
# text_pixel_pipe

Parametrised, pipelined text-mode pixel generator between the VGA timing controller and the video/font memories. It tracks the character cell under the scan position incrementally (no dividers) and applies a row-granular scroll offset. It reads the character code from synchronous video memory, then the glyph line from synchronous font ROM, and emits the pixel colour with a blinking underline cursor at a fixed 4-cycle latency.

## Interface
Parameters:
- CHAR_W, 9, glyph width in pixels
- CHAR_H, 16, glyph height in pixels
- COLS, 70, text columns
- ROWS, 30, text rows
- COLOR_W, 24, colour width
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock
- clrn  in  1  asynchronous active-low reset
- valid_in  in  1  display-enable for h_addr/v_addr
- h_addr  in  10  scan x; increments by 1 each valid cycle within a line
- v_addr  in  10  scan y
- roll_row  in  $clog2(ROWS)  scroll offset in rows, < ROWS
- cursor_en  in  1  cursor enable
- cursor_col  in  $clog2(COLS)  cursor column
- cursor_row  in  $clog2(ROWS)  cursor row (screen coordinates, post-scroll)
- color_text  in  COLOR_W  foreground
- color_background  in  COLOR_W  background
- vm_addr  out  $clog2(COLS*ROWS)  video memory address
- vm_data  in  8  ASCII code, 1-cycle read latency
- font_addr  out  8+$clog2(CHAR_H)  font ROM address
- font_line  in  CHAR_W  glyph row, 1-cycle read latency; bit 0 = leftmost pixel
- pixel  out  COLOR_W  output colour
- pixel_valid  out  1  pixel qualifies valid_in delayed by 4

## Operation
- Cell tracker (registered): on valid_in && h_addr==0, set offX=0, col=0, else on valid_in increment offX, wrapping at CHAR_W-1 and incrementing col. col saturates at COLS; col==COLS means outside the text area.
- Vertical, evaluated at h_addr==0 with valid_in: v_addr==0 sets offY=0, row=0, else if v_addr != last_v, increment offY, wrapping at CHAR_H-1 and incrementing row. row saturates at ROWS. last_v is updated every line start.
- Memory row = row+roll_row, minus ROWS when the sum is ≥ ROWS. vm_addr = memrow*COLS + col, computed from stage-1 registers.
- font_addr = {vm_data, offY_d}, with offY delayed to match.
- Colour select: font_line[offX_d] ? color_text : color_background.
- Outside the text area (col==COLS or row==ROWS): background, regardless of memory contents.
- Cursor: blink counter increments on every valid_in && h_addr==0 && v_addr==0. At BLINK_FRAMES-1 it wraps to 0 and toggles the phase bit.
- Cursor pixel is forced to color_text when cursor_en && phase && row==cursor_row && col==cursor_col && offY ≥ CHAR_H-2.
- Cursor position is compared in screen coordinates; roll_row does not apply.

## Timing
- Cycle 0: h_addr/v_addr presented. Cycle 1: tracker registers and vm_addr valid. Cycle 2: vm_data returns and font_addr is registered. Cycle 3: font_line returns. Cycle 4: pixel and pixel_valid registered.
- Side-band signals (offX, offY, in_area, cursor hit, valid) are delayed alongside so they align at cycle 4.
- Throughput: 1 pixel per clock, no stalls.
- When pixel_valid==0, pixel is 0 (blanking).
- roll_row, cursor and colour inputs are sampled at cycle 1. Changes mid-frame take effect from the next sampled pixel; there is no frame-boundary latching.
- Reset (async, any time): all pipeline registers, counters, phase, vm_addr, font_addr, pixel and pixel_valid go to 0. Output resumes correctly from the next line start after release.
- A first line after reset with h_addr≠0: the tracker holds 0 until h_addr==0.

## Structure
- Shared package holds: the wrap/saturate helper functions, cursor height (2 lines), and the latency constant (4).
- Sub-module cell_tracker holds the incremental col/offX/row/offY counters and last_v. The top level holds the address math, delay line, blink logic and colour mux.

## Test plan
- Reset mid-frame with clrn pulsed during valid output -> pixel=0 and pixel_valid=0 immediately; after release, a correct pixel appears 4 cycles after the next h_addr==0.
- Defaults, vm 'A' (0x41) at cell (0,0), font row 0 = 9'h001 -> pixel at (0,0) = color_text and (1,0) = color_background, both 4 cycles after input; vm_addr=0 at cycle 1.
- h_addr=629 (col 69) -> vm_addr=69; h_addr=630 -> background with no memory dependence.
- roll_row=29, scan row 1 -> vm_addr = 0*70+col (wrap); roll_row=5, row 0 -> vm_addr = 350+col.
- cursor_en=1 at (3,2), BLINK_FRAMES=2 -> underline on v_addr 46–47, h_addr 27–35 only while phase=1; phase toggles every 2 frames.
- Continuous valid stream across a line end with v_addr incrementing -> offY steps once per line and row increments every 16 lines.
